// File: rtl/ahb_sram_ws.sv
// ahb_sram_ws: AHB-Lite slave SRAM with programmable wait states, ERROR
// responses for illegal transfers, read-after-write forwarding and a
// handshaked side load port used for boot-image download.
//
// Ports:
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   HSEL, HREADY         decoder select, bus ready (address phase qualifier)
//   HADDR, HTRANS        byte address, transfer type (bit 1 = NONSEQ/SEQ)
//   HWRITE, HSIZE        direction, size (0 byte, 1 halfword, 2 word)
//   HWDATA               write data, data phase
//   HREADYOUT, HRESP     slave ready, response (1 = ERROR)
//   HRDATA               registered read data (full 32-bit word)
//   LD_WR, LD_ADDR,      load-port write request, word index, word data
//   LD_DATA, LD_READY    LD_READY low only while an AHB write commits
module ahb_sram_ws #(
    parameter int MEMWIDTH    = 14,
    parameter int WAIT_STATES = 0,
    parameter bit ERR_EN      = 1'b1
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    input  logic                HSEL,
    input  logic                HREADY,
    input  logic [31:0]         HADDR,
    input  logic [1:0]          HTRANS,
    input  logic                HWRITE,
    input  logic [2:0]          HSIZE,
    input  logic [31:0]         HWDATA,
    output logic                HREADYOUT,
    output logic                HRESP,
    output logic [31:0]         HRDATA,
    input  logic                LD_WR,
    input  logic [MEMWIDTH-3:0] LD_ADDR,
    input  logic [31:0]         LD_DATA,
    output logic                LD_READY
);
    localparam int AW    = MEMWIDTH - 2;
    localparam int DEPTH = 2 ** AW;
    localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

    // Byte lanes touched by a transfer; misaligned halfwords/words fall
    // onto their aligned lanes, which is the forced alignment used when
    // error checking is disabled.
    function automatic logic [3:0] lane_strobe(input logic [2:0] size, input logic [1:0] lo);
        logic [3:0] strb;
        case (size)
            3'd0:    strb = 4'b0001 << lo;
            3'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wr_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? wr_word[8*b +: 8] : old_word[8*b +: 8];
        return res;
    endfunction

    logic [31:0]   mem [DEPTH];

    state_t        state, state_next;
    logic [2:0]    cnt, cnt_next;
    logic          active, illegal, ready_phase, accept;
    logic [AW-1:0] haddr_idx;

    // Transfer currently in its data phase (OKAY transfers only)
    logic          dp_valid;
    logic          dp_write;
    logic [AW-1:0] dp_idx;
    logic [3:0]    dp_strb;

    logic          ahb_commit, ld_commit, rd_load;
    logic [AW-1:0] rd_idx;
    logic [31:0]   rd_word;

    logic          unused_bits;
    assign unused_bits = ^{HADDR[31:MEMWIDTH], HTRANS[0]};

    assign haddr_idx   = HADDR[MEMWIDTH-1:2];
    assign active      = HSEL & HREADY & HTRANS[1];
    assign illegal     = ERR_EN && ((HSIZE > 3'd2) ||
                                    (HSIZE == 3'd1 && HADDR[0]) ||
                                    (HSIZE == 3'd2 && HADDR[1:0] != 2'b00));
    assign ready_phase = (state == IDLE) || (state == ERR2);
    assign accept      = active & ready_phase;

    // A pending write can only sit in IDLE during its last data-phase cycle.
    assign ahb_commit  = dp_valid & dp_write & (state == IDLE);
    assign LD_READY    = ~ahb_commit;
    assign ld_commit   = LD_WR & LD_READY;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        HREADYOUT  = 1'b1;
        HRESP      = 1'b0;
        case (state)
            IDLE, ERR2: begin
                HRESP      = (state == ERR2);
                state_next = IDLE;
                if (active) begin
                    if (illegal) begin
                        state_next = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WS_LOAD;
                    end
                end
            end
            WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt == 3'd0) state_next = IDLE;
                else             cnt_next   = cnt - 3'd1;
            end
            ERR1: begin
                HREADYOUT  = 1'b0;
                HRESP      = 1'b1;
                state_next = ERR2;
            end
            default: state_next = IDLE;
        endcase
    end

    // HRDATA is loaded on the edge that opens the last data-phase cycle:
    // the address edge itself with no wait states, else the final WAIT edge.
    // Any write landing on that same edge is merged in.
    always_comb begin
        if (WAIT_STATES == 0) begin
            rd_load = accept & ~illegal & ~HWRITE;
            rd_idx  = haddr_idx;
        end else begin
            rd_load = (state == WAIT) & (cnt == 3'd0) & dp_valid & ~dp_write;
            rd_idx  = dp_idx;
        end
        rd_word = mem[rd_idx];
        if (ahb_commit && dp_idx == rd_idx)
            rd_word = merge_bytes(rd_word, HWDATA, dp_strb);
        if (ld_commit && LD_ADDR == rd_idx)
            rd_word = LD_DATA;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            dp_valid <= 1'b0;
            HRDATA   <= 32'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (ready_phase)
                dp_valid <= accept & ~illegal;
            if (rd_load)
                HRDATA <= rd_word;
        end
    end

    always_ff @(posedge HCLK) begin
        if (accept) begin
            dp_write <= HWRITE;
            dp_idx   <= haddr_idx;
            dp_strb  <= lane_strobe(HSIZE, HADDR[1:0]);
        end
    end

    always_ff @(posedge HCLK) begin
        if (ahb_commit)
            mem[dp_idx] <= merge_bytes(mem[dp_idx], HWDATA, dp_strb);
        else if (ld_commit)
            mem[LD_ADDR] <= LD_DATA;
    end

endmodule
